conv_layer_sched: RTL

Sequencer for one convolution layer on the existing datapath: ifm RAM, weight RAM, muladd, acc, and out RAM.
- Walks loop nest m,r,c (outer) then n,i,j (reduction), generating read addresses and enables for both input buffers.
- Delays control through the RAM and multiplier-adder pipeline to drive accumulator clear/enable and output write strobe/address.
- Replaces the free-running loop counter and the neuron/plane ready detection with one start/busy/done controlled block.

---
 rtl/conv_layer_sched.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sched
// Brief    : Start/busy/done sequencer for one convolution layer. Walks the
//            m,r,c / n,i,j loop nest issuing ifm and weight reads, then
//            delays control through the RAM and muladd pipeline to drive the
//            accumulator and output buffer strobes.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sched #(
  parameter int M_OUT   = 2,
  parameter int N_IN    = 2,
  parameter int R_OUT   = 4,
  parameter int C_OUT   = 4,
  parameter int K       = 3,
  parameter int RAM_LAT = 1,
  parameter int MAC_LAT = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ifm_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              plane_rdy
);

  // Input plane geometry including the kernel halo
  localparam int unsigned c_W  = C_OUT + K - 1;
  localparam int unsigned c_H  = R_OUT + K - 1;
  localparam int unsigned c_HW = c_H * c_W;

  // Pipeline depths: acc control at c_L, output write one stage later
  localparam int c_L  = RAM_LAT + MAC_LAT;
  localparam int c_DL = c_L + 1;
  localparam int c_D  = c_L + 1;

  // Counter widths sized to hold the parameter value itself
  localparam int c_MW = $clog2(M_OUT + 1);
  localparam int c_NW = $clog2(N_IN + 1);
  localparam int c_RW = $clog2(R_OUT + 1);
  localparam int c_CW = $clog2(C_OUT + 1);
  localparam int c_KW = $clog2(K + 1);
  localparam int c_DW = $clog2(c_D + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nx;

  logic [c_MW-1:0] r_m, w_m_nx;
  logic [c_RW-1:0] r_r, w_r_nx;
  logic [c_CW-1:0] r_c, w_c_nx;
  logic [c_NW-1:0] r_n, w_n_nx;
  logic [c_KW-1:0] r_i, w_i_nx;
  logic [c_KW-1:0] r_j, w_j_nx;
  logic [c_DW-1:0] r_drain;

  logic w_cnt_clr, w_cnt_adv, w_issue_nx, w_done_nx;
  logic w_m_end, w_r_end, w_c_end, w_n_end, w_i_end, w_j_end;
  logic w_cy_n, w_cy_c, w_cy_r, w_cy_m, w_last;

  logic              r_ifm_en, r_done;
  logic [ADDR_W-1:0] r_ifm_addr, r_w_addr;

  logic [c_DL-1:0]   r_vld_pipe, r_first_pipe, r_last_pipe, r_rce_pipe;
  logic [ADDR_W-1:0] r_oaddr_pipe [c_DL];
  logic              w_p_first, w_p_last, w_p_rce;
  logic [ADDR_W-1:0] w_p_oaddr;

  function automatic logic [ADDR_W-1:0] f_ifm_addr(
    input logic [c_NW-1:0] a_n, input logic [c_RW-1:0] a_r,
    input logic [c_CW-1:0] a_c, input logic [c_KW-1:0] a_i,
    input logic [c_KW-1:0] a_j);
    int unsigned v;
    v = 32'(a_n) * c_HW + (32'(a_r) + 32'(a_i)) * c_W + 32'(a_c) + 32'(a_j);
    return ADDR_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] f_w_addr(
    input logic [c_MW-1:0] a_m, input logic [c_NW-1:0] a_n,
    input logic [c_KW-1:0] a_i, input logic [c_KW-1:0] a_j);
    int unsigned v;
    v = ((32'(a_m) * 32'(N_IN) + 32'(a_n)) * 32'(K) + 32'(a_i)) * 32'(K) + 32'(a_j);
    return ADDR_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] f_out_addr(
    input logic [c_MW-1:0] a_m, input logic [c_RW-1:0] a_r,
    input logic [c_CW-1:0] a_c);
    int unsigned v;
    v = (32'(a_m) * 32'(R_OUT) + 32'(a_r)) * 32'(C_OUT) + 32'(a_c);
    return ADDR_W'(v);
  endfunction

  // Loop-end detection and the carry chain j -> i -> n -> c -> r -> m
  assign w_j_end = (r_j == c_KW'(K - 1));
  assign w_i_end = (r_i == c_KW'(K - 1));
  assign w_n_end = (r_n == c_NW'(N_IN - 1));
  assign w_c_end = (r_c == c_CW'(C_OUT - 1));
  assign w_r_end = (r_r == c_RW'(R_OUT - 1));
  assign w_m_end = (r_m == c_MW'(M_OUT - 1));
  assign w_cy_n  = w_j_end & w_i_end;
  assign w_cy_c  = w_cy_n & w_n_end;
  assign w_cy_r  = w_cy_c & w_c_end;
  assign w_cy_m  = w_cy_r & w_r_end;
  assign w_last  = w_cy_m & w_m_end;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode; counters hold the tuple currently on the issue outputs
  always_comb begin
    w_state_nx = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_adv  = 1'b0;
    w_issue_nx = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (start) begin
          w_state_nx = S_RUN;
          w_issue_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nx = S_DRAIN;
          w_cnt_clr  = 1'b1;
        end else begin
          w_cnt_adv  = 1'b1;
          w_issue_nx = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == c_DW'(c_D - 1)) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Next loop-nest tuple: clear, advance with carries, or hold
  always_comb begin
    w_m_nx = r_m;
    w_r_nx = r_r;
    w_c_nx = r_c;
    w_n_nx = r_n;
    w_i_nx = r_i;
    w_j_nx = r_j;
    if (w_cnt_clr) begin
      w_m_nx = '0;
      w_r_nx = '0;
      w_c_nx = '0;
      w_n_nx = '0;
      w_i_nx = '0;
      w_j_nx = '0;
    end else if (w_cnt_adv) begin
      w_j_nx = w_j_end ? '0 : r_j + c_KW'(1);
      if (w_j_end) w_i_nx = w_i_end ? '0 : r_i + c_KW'(1);
      if (w_cy_n)  w_n_nx = w_n_end ? '0 : r_n + c_NW'(1);
      if (w_cy_c)  w_c_nx = w_c_end ? '0 : r_c + c_CW'(1);
      if (w_cy_r)  w_r_nx = w_r_end ? '0 : r_r + c_RW'(1);
      if (w_cy_m)  w_m_nx = w_m_end ? '0 : r_m + c_MW'(1);
    end
  end

  // Loop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m <= '0;
      r_r <= '0;
      r_c <= '0;
      r_n <= '0;
      r_i <= '0;
      r_j <= '0;
    end else begin
      r_m <= w_m_nx;
      r_r <= w_r_nx;
      r_c <= w_c_nx;
      r_n <= w_n_nx;
      r_i <= w_i_nx;
      r_j <= w_j_nx;
    end
  end

  // Drain timer runs only while waiting for the pipeline to empty
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_drain <= '0;
    else if (r_state == S_DRAIN) r_drain <= r_drain + c_DW'(1);
    else                         r_drain <= '0;
  end

  // Issue registers: enable and addresses computed from the upcoming tuple
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifm_en   <= 1'b0;
      r_ifm_addr <= '0;
      r_w_addr   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_ifm_en   <= w_issue_nx;
      r_ifm_addr <= w_issue_nx ? f_ifm_addr(w_n_nx, w_r_nx, w_c_nx, w_i_nx, w_j_nx) : '0;
      r_w_addr   <= w_issue_nx ? f_w_addr(w_m_nx, w_n_nx, w_i_nx, w_j_nx) : '0;
      r_done     <= w_done_nx;
    end
  end

  // Per-issue tags entering the control delay line, gated by issue-valid
  assign w_p_first = r_ifm_en & (r_n == '0) & (r_i == '0) & (r_j == '0);
  assign w_p_last  = r_ifm_en & w_n_end & w_i_end & w_j_end;
  assign w_p_rce   = w_r_end & w_c_end;
  assign w_p_oaddr = f_out_addr(r_m, r_r, r_c);

  // Control delay line matching RAM read plus muladd plus acc register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe   <= '0;
      r_first_pipe <= '0;
      r_last_pipe  <= '0;
      r_rce_pipe   <= '0;
      for (int s = 0; s < c_DL; s++) r_oaddr_pipe[s] <= '0;
    end else begin
      for (int s = c_DL - 1; s > 0; s--) begin
        r_vld_pipe[s]   <= r_vld_pipe[s-1];
        r_first_pipe[s] <= r_first_pipe[s-1];
        r_last_pipe[s]  <= r_last_pipe[s-1];
        r_rce_pipe[s]   <= r_rce_pipe[s-1];
        r_oaddr_pipe[s] <= r_oaddr_pipe[s-1];
      end
      r_vld_pipe[0]   <= r_ifm_en;
      r_first_pipe[0] <= w_p_first;
      r_last_pipe[0]  <= w_p_last;
      r_rce_pipe[0]   <= w_p_rce;
      r_oaddr_pipe[0] <= w_p_oaddr;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign ifm_en    = r_ifm_en;
  assign w_en      = r_ifm_en;
  assign ifm_addr  = r_ifm_addr;
  assign w_addr    = r_w_addr;
  assign acc_en    = r_vld_pipe[c_L-1];
  assign acc_clr   = r_vld_pipe[c_L-1] & r_first_pipe[c_L-1];
  assign out_we    = r_last_pipe[c_L];
  assign out_addr  = r_oaddr_pipe[c_L];
  assign plane_rdy = r_last_pipe[c_L] & r_rce_pipe[c_L];

endmodule
`default_nettype wire
